// File: rtl/cbd_timer_sched.sv
// cbd_timer_sched
// Shares one down-count timer between NREQ requesters. A round-robin
// arbiter grants one pending requester, loads its delay into the timer and
// decrements it on TICK-qualified cycles. When the count is exhausted the
// granted requester receives a one-cycle DONE pulse.
//
// Ports
//   CLK   rising-edge clock
//   CD    asynchronous active-high clear
//   TICK  count enable (EN && CAI of the counter datapath)
//   REQ   level request per requester, held until DONE
//   DLY   per-requester delay, DLY[i*WIDTH +: WIDTH], sampled at grant
//   GNT   one-hot registered grant
//   DONE  one-hot registered expiry pulse (one cycle)
//   BUSY  high whenever a grant is outstanding
//   CNT   current timer value
module cbd_timer_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  CD,
  input  logic                  TICK,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DLY,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      CNT
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     gidx, gidx_n;
  logic [IW-1:0]     sel, cand, nxt;
  logic              sel_vld;
  int unsigned       idx;
  logic [WIDTH-1:0]  dly_sel;
  logic [NREQ-1:0]   gnt_n, done_n;
  logic [WIDTH-1:0]  cnt_n;

  // Round-robin pick: first asserted request at or after ptr, wrapping.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(ptr) + k) % NREQ;
      cand = IW'(idx);
      if (!sel_vld && REQ[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  // Delay of the selected requester (mux keeps the part-select constant).
  always_comb begin
    dly_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == sel) begin
        dly_sel = DLY[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer value after serving (or aborting) the granted requester.
  assign nxt = (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    gnt_n   = GNT;
    done_n  = '0;
    cnt_n   = CNT;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          gidx_n  = sel;
          gnt_n   = ONE << sel;
          cnt_n   = dly_sel;
          state_n = COUNT;
        end
      end
      COUNT: begin
        // Abort outranks expiry so a withdrawn requester never sees DONE.
        if (!REQ[gidx]) begin
          gnt_n   = '0;
          ptr_n   = nxt;
          state_n = IDLE;
        end else if (CNT == '0) begin
          done_n  = GNT;
          state_n = EXPIRE;
        end else if (TICK) begin
          cnt_n = CNT - WIDTH'(1);
        end
      end
      EXPIRE: begin
        gnt_n   = '0;
        ptr_n   = nxt;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      GNT   <= '0;
      DONE  <= '0;
      CNT   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
      GNT   <= gnt_n;
      DONE  <= done_n;
      CNT   <= cnt_n;
    end
  end

  assign BUSY = (state != IDLE);

endmodule
